// File: rtl/sobol_sng_stream_if.sv
// Operand handshake, Sobol RNG coupling and stochastic bit stream of the
// SNG stage, bundled so the source/RNG side and the SNG side share one port.
interface sobol_sng_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] inData;
    logic             inValid;
    logic             inReady;
    logic             rngEnable;
    logic [WIDTH-1:0] sobolSeq;
    logic             bitOut;
    logic             bitValid;
    logic [WIDTH-1:0] onesCnt;
    logic             done;

    modport master (
        output inData, inValid, sobolSeq,
        input  inReady, rngEnable, bitOut, bitValid, onesCnt, done
    );

    modport slave (
        input  inData, inValid, sobolSeq,
        output inReady, rngEnable, bitOut, bitValid, onesCnt, done
    );
endinterface

// File: rtl/sobol_sng_stream.sv
// Sobol-driven stochastic number generator: one operand in, one full Sobol
// period of comparator bits out, plus an exact count of the emitted 1s.
module sobol_sng_stream #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sobol_sng_stream_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state;
    state_e           next_state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] period_cnt;
    logic [WIDTH-1:0] ones_acc;
    logic [WIDTH-1:0] ones_cnt;
    logic             bit_out;
    logic             bit_valid;
    logic             cmp;
    logic             last_cycle;

    // The sample on sobolSeq is the one before the RNG advances on this edge.
    assign cmp        = (data_q > bus.sobolSeq);
    assign last_cycle = (period_cnt == {WIDTH{1'b1}});

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.inValid) next_state = RUN;
            RUN:     if (last_cycle)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            period_cnt <= '0;
            ones_acc   <= '0;
            ones_cnt   <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_valid <= 1'b0;
                    if (bus.inValid) begin
                        data_q     <= bus.inData;
                        period_cnt <= '0;
                        ones_acc   <= '0;
                    end
                end
                RUN: begin
                    bit_out    <= cmp;
                    bit_valid  <= 1'b1;
                    ones_acc   <= ones_acc + {{(WIDTH-1){1'b0}}, cmp};
                    period_cnt <= period_cnt + 1'b1;
                    // At most 2^WIDTH-1 ones per period, so the sum fits WIDTH bits.
                    if (last_cycle) begin
                        ones_cnt <= ones_acc + {{(WIDTH-1){1'b0}}, cmp};
                    end
                end
                DONE: begin
                    bit_valid <= 1'b0;
                end
                default: begin
                    bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inReady   = (state == IDLE);
    assign bus.rngEnable = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.bitOut    = bit_out;
    assign bus.bitValid  = bit_valid;
    assign bus.onesCnt   = ones_cnt;

endmodule
